// File: rtl/synthetic_delay_logic.sv
// synthetic_delay_logic: y = ~b & (a | ~c) built from three minterms,
// plus an enabled DEPTH-stage delay line with fill flag and toggle count.
module synthetic_delay_logic #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             en,
  output logic             y,
  output logic [2:0]       terms,
  output logic             y_dly,
  output logic             dly_valid,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             n1;
  logic             n2;
  logic             n3;
  logic [1:0]       sync_q;
  logic             adv;
  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign n1    = ~a & ~b & ~c;
  assign n2    =  a & ~b & ~c;
  assign n3    =  a & ~b &  c;
  assign terms = {n3, n2, n1};
  assign y     = n1 | n2 | n3;

  // Assert immediately, release only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign adv = en & sync_q[1];

  // Shift, fill and saturating toggle count for one enabled edge
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    if (adv) begin
      stage_d[0] = y;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
      if (fill_q != FULL) begin
        fill_d = fill_q + FW'(1);
      end
      if ((stage_d[DEPTH-1] != stage_q[DEPTH-1]) &&
          (cnt_q != CMAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Delay-line state; reset discards every in-flight sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_dly      = stage_q[DEPTH-1];
  assign dly_valid  = (fill_q == FULL);
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_synthetic_delay_logic.sv
// tb_synthetic_delay_logic: directed checks of the logic function and
// delay line, with a DEPTH=2/CNT_W=4 and a DEPTH=1/CNT_W=8 instance.
module tb_synthetic_delay_logic;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       c = 1'b0;
  logic       en = 1'b0;
  logic       y2, y1;
  logic [2:0] t2, t1;
  logic       yd2, yd1;
  logic       v2, v1;
  logic [3:0] c2;
  logic [7:0] c1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  synthetic_delay_logic #(.DEPTH(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en),
    .y(y2), .terms(t2), .y_dly(yd2), .dly_valid(v2),
    .toggle_cnt(c2)
  );

  synthetic_delay_logic #(.DEPTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en),
    .y(y1), .terms(t1), .y_dly(yd1), .dly_valid(v1),
    .toggle_cnt(c1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0;
    {a, b, c} = 3'b000;
    #1;
    checks++;
    if ({yd2, v2, c2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_d2: got %h want %h", {yd2, v2, c2}, 6'b0);
    end
    checks++;
    if ({yd1, v1, c1} !== 10'b0) begin
      errors++;
      $display("FAIL reset_d1: got %h want %h", {yd1, v1, c1}, 10'b0);
    end
    checks++;
    if ({y2, t2} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_comb: got %b want %b", {y2, t2}, 4'b1001);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic test_comb();
    logic [7:0] tab;
    int ord [8];
    logic [2:0] et;
    logic [2:0] v;
    tab = 8'b0011_0001;
    ord = '{7, 0, 5, 2, 1, 3, 4, 6};
    for (int k = 0; k < 8; k++) begin
      v = ord[k][2:0];
      {a, b, c} = v;
      #10;
      case (v)
        3'b000:  et = 3'b001;
        3'b100:  et = 3'b010;
        3'b101:  et = 3'b100;
        default: et = 3'b000;
      endcase
      checks++;
      if ({y2, t2} !== {tab[v], et}) begin
        errors++;
        $display("FAIL comb_%b: got %b want %b", v, {y2, t2}, {tab[v], et});
      end
      checks++;
      if (y1 !== tab[v]) begin
        errors++;
        $display("FAIL comb1_%b: got %b want %b", v, y1, tab[v]);
      end
    end
  endtask

  task automatic test_latency();
    en = 1'b1;
    {a, b, c} = 3'b000;
    step();
    {a, b, c} = 3'b111;
    checks++;
    if ({yd2, v2, c2} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL lat_e0_d2: got %h want %h", {yd2, v2, c2}, 6'h00);
    end
    checks++;
    if ({yd1, v1, c1} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL lat_e0_d1: got %h want %h", {yd1, v1, c1}, {1'b1, 1'b1, 8'd1});
    end
    step();
    checks++;
    if ({yd2, v2, c2} !== {1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL lat_e1_d2: got %h want %h", {yd2, v2, c2}, {1'b1, 1'b1, 4'd1});
    end
    checks++;
    if ({yd1, v1, c1} !== {1'b0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL lat_e1_d1: got %h want %h", {yd1, v1, c1}, {1'b0, 1'b1, 8'd2});
    end
    step();
    checks++;
    if ({yd2, v2, c2} !== {1'b0, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL lat_e2_d2: got %h want %h", {yd2, v2, c2}, {1'b0, 1'b1, 4'd2});
    end
    checks++;
    if ({yd1, v1, c1} !== {1'b0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL lat_e2_d1: got %h want %h", {yd1, v1, c1}, {1'b0, 1'b1, 8'd2});
    end
  endtask

  task automatic test_hold();
    logic [2:0] pat [5];
    logic       ey  [5];
    pat = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b001};
    ey  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      {a, b, c} = pat[k];
      step();
      checks++;
      if (y2 !== ey[k]) begin
        errors++;
        $display("FAIL hold_y%0d: got %b want %b", k, y2, ey[k]);
      end
      checks++;
      if ({yd2, v2, c2, yd1, v1, c1} !==
          {1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 8'd2}) begin
        errors++;
        $display("FAIL hold_st%0d: got %h want %h", k,
                 {yd2, v2, c2, yd1, v1, c1},
                 {1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 8'd2});
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] e2;
    logic [7:0] e1;
    logic       ed2;
    logic       ed1;
    en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      {a, b, c} = (j % 2 == 0) ? 3'b000 : 3'b111;
      step();
      e2  = (j == 0) ? 4'd2 : ((j + 2 > 15) ? 4'd15 : 4'(j + 2));
      ed2 = (j % 2 == 1);
      e1  = 8'(j + 3);
      ed1 = (j % 2 == 0);
      checks++;
      if ({yd2, c2} !== {ed2, e2}) begin
        errors++;
        $display("FAIL toggle_d2_%0d: got %h want %h", j, {yd2, c2}, {ed2, e2});
      end
      checks++;
      if ({yd1, c1} !== {ed1, e1}) begin
        errors++;
        $display("FAIL toggle_d1_%0d: got %h want %h", j, {yd1, c1}, {ed1, e1});
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    {a, b, c} = 3'b000;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({yd2, v2, c2, yd1, v1, c1} !== 15'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h",
               {yd2, v2, c2, yd1, v1, c1}, 15'b0);
    end
    checks++;
    if ({y2, t2} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_comb: got %b want %b", {y2, t2}, 4'b1001);
    end
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({yd2, v2, yd1, v1} !== 4'b0) begin
        errors++;
        $display("FAIL sync_%0d: got %b want %b", k, {yd2, v2, yd1, v1}, 4'b0);
      end
    end
    step();
    checks++;
    if ({yd2, v2, c2} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL refill1_d2: got %h want %h", {yd2, v2, c2}, 6'h00);
    end
    checks++;
    if ({yd1, v1, c1} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL refill1_d1: got %h want %h", {yd1, v1, c1}, {1'b1, 1'b1, 8'd1});
    end
    step();
    checks++;
    if ({yd2, v2, c2} !== {1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL refill2_d2: got %h want %h", {yd2, v2, c2}, {1'b1, 1'b1, 4'd1});
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_latency();
    test_hold();
    test_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
